// File: rtl/sum_mult_engine.sv
// Sums every positive integer below n that is a multiple of a or b, with common
// multiples counted once, by merging two ascending multiple streams.
module sum_mult_engine #(
    parameter int N_W   = 16,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    input  logic [N_W-1:0]   a,
    input  logic [N_W-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic [CNT_W-1:0] terms,
    output logic             ovf
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    // The widened sum exposes every bit lost when a term wider than acc is added.
    localparam int SUM_W = ((ACC_W > N_W + 1) ? ACC_W : N_W + 1) + 1;

    state_t             state_q, state_d;
    logic [N_W-1:0]     n_q, n_d, a_q, a_d, b_q, b_d;
    logic [N_W:0]       ma_q, ma_d, mb_q, mb_d;
    logic [ACC_W-1:0]   acc_q, acc_d, result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, terms_q, terms_d;
    logic               ovf_q, ovf_d;

    logic               live_a, live_b, take_a, take_b;
    logic [N_W:0]       term;
    logic [SUM_W-1:0]   acc_sum;
    logic [CNT_W:0]     cnt_sum;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        n_d      = n_q;
        a_d      = a_q;
        b_d      = b_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        terms_d  = terms_q;

        live_a  = (a_q != '0) && (ma_q < {1'b0, n_q});
        live_b  = (b_q != '0) && (mb_q < {1'b0, n_q});
        // Equal heads are taken from both streams at once, which removes the double count.
        take_a  = live_a && (!live_b || (ma_q <= mb_q));
        take_b  = live_b && (!live_a || (mb_q <= ma_q));
        term    = take_a ? ma_q : mb_q;
        acc_sum = SUM_W'(acc_q) + SUM_W'(term);
        cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n;
                    a_d     = a;
                    b_d     = b;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ma_d    = {1'b0, a_q};
                mb_d    = {1'b0, b_q};
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!live_a && !live_b) begin
                    result_d = acc_q;
                    terms_d  = cnt_q;
                    state_d  = S_DONE;
                end else begin
                    acc_d = acc_sum[ACC_W-1:0];
                    cnt_d = cnt_sum[CNT_W-1:0];
                    if ((|acc_sum[SUM_W-1:ACC_W]) || cnt_sum[CNT_W]) begin
                        ovf_d = 1'b1;
                    end
                    if (take_a) ma_d = ma_q + {1'b0, a_q};
                    if (take_b) mb_d = mb_q + {1'b0, b_q};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, and every register
    // (working regs included) is cleared by reset so an aborted run leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            terms_q  <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            terms_q  <= terms_d;
        end
    end

    assign busy   = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign terms  = terms_q;
    assign ovf    = ovf_q;

endmodule
